// File: rtl/burst_seq.sv
// burst_seq: interrupter burst sequencer gating whole reference cycles with sweep and holdoff (optional overcurrent stop via BURST_SEQ_OCD_EN)
module burst_seq #(
  parameter int CLK_MHZ       = 100,
  parameter int GEN_PARAMETER = 255,
  parameter int CYC_W         = 8,
  parameter int HOLDOFF_CYC   = 1000,
  localparam int GW           = $clog2(GEN_PARAMETER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             ref_in,
  input  logic [GW-1:0]    gen_start,
  input  logic [GW-1:0]    gen_step,
  input  logic             sweep_dn,
  input  logic [CYC_W-1:0] on_cyc,
  output logic [GW-1:0]    gen_val,
  output logic             gate,
  output logic             busy,
  output logic             burst_done
`ifdef BURST_SEQ_OCD_EN
  ,
  input  logic             ocd,
  output logic             fault
`endif
);
  localparam int HW = HOLDOFF_CYC > 1 ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYC == 0 ? 0 : HOLDOFF_CYC - 1);
  localparam logic [GW:0] MAXW = (GW + 1)'(GEN_PARAMETER);
  if (CLK_MHZ < 1) begin : g_clk_chk
    $error("CLK_MHZ must be positive");
  end
  typedef enum logic [1:0] {IDLE, ARM, RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic ref_q, rise, fall, ref_edge;
  logic [GW-1:0] gen_val_q, gen_val_d, step_q, step_d, start_c, sweep_c;
  logic [GW:0] sum, diff;
  logic [CYC_W-1:0] on_q, on_d, cyc_q, cyc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic dn_q, dn_d, gate_q, gate_d, done_q, done_d;
  logic ocd_stop, start_ok;
  assign rise     = ref_in & ~ref_q;
  assign fall     = ~ref_in & ref_q;
  assign ref_edge = rise | fall;
  assign start_c  = ({1'b0, gen_start} > MAXW) ? MAXW[GW-1:0] : gen_start;
  assign sum      = {1'b0, gen_val_q} + {1'b0, step_q};
  assign diff     = {1'b0, gen_val_q} - {1'b0, step_q};
  assign sweep_c  = dn_q ? (diff[GW] ? '0 : diff[GW-1:0]) : (sum > MAXW ? MAXW[GW-1:0] : sum[GW-1:0]);
`ifdef BURST_SEQ_OCD_EN
  logic ocd_stop_q, fault_q;
  assign ocd_stop = (state_q == RUN) & (ocd_stop_q | ocd);
  assign start_ok = ~fault_q;
  assign fault    = fault_q;
  // sticky overcurrent stop for the current burst, and a fault latch held until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocd_stop_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      ocd_stop_q <= ocd_stop;
      fault_q    <= fault_q | ocd;
    end
  end
`else
  assign ocd_stop = 1'b0;
  assign start_ok = 1'b1;
`endif
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ref_q     <= 1'b0;
      gen_val_q <= '0;
      step_q    <= '0;
      on_q      <= '0;
      cyc_q     <= '0;
      hold_q    <= '0;
      dn_q      <= 1'b0;
      gate_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_in;
      gen_val_q <= gen_val_d;
      step_q    <= step_d;
      on_q      <= on_d;
      cyc_q     <= cyc_d;
      hold_q    <= hold_d;
      dn_q      <= dn_d;
      gate_q    <= gate_d;
      done_q    <= done_d;
    end
  end
  // next state: arm on request, run whole cycles with sweep, end only on a falling edge, then hold off
  always_comb begin
    state_d   = state_q;
    gen_val_d = gen_val_q;
    step_d    = step_q;
    on_d      = on_q;
    dn_d      = dn_q;
    cyc_d     = cyc_q;
    hold_d    = hold_q;
    gate_d    = gate_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        gen_val_d = start_c;
        if (trig && on_cyc != '0 && start_ok) begin
          state_d = ARM;
          on_d    = on_cyc;
          step_d  = gen_step;
          dn_d    = sweep_dn;
        end
      end
      ARM: begin
        if (!trig) state_d = IDLE;
        else if (rise) begin
          gate_d  = 1'b1;
          cyc_d   = on_q;
          state_d = RUN;
        end
      end
      RUN: begin
        if (fall) cyc_d = cyc_q - 1'b1;
        if (fall && (cyc_q == CYC_W'(1) || !trig || ocd_stop)) begin
          gate_d    = 1'b0;
          done_d    = 1'b1;
          hold_d    = HOLD_LOAD;
          gen_val_d = start_c;
          state_d   = HOLD;
        end else if (ref_edge) gen_val_d = sweep_c;
      end
      HOLD: begin
        gate_d = 1'b0;
        if (hold_q == '0) state_d = IDLE;
        else hold_d = hold_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs: busy decoded from state, the rest straight from registers
  always_comb begin
    busy       = state_q != IDLE;
    gen_val    = gen_val_q;
    gate       = gate_q;
    burst_done = done_q;
  end
endmodule

// File: tb/tb_burst_seq.sv
// tb_burst_seq: randomized burst stimulus with a queued reference model and a decoupled output monitor
module tb_burst_seq;
  localparam int GP = 255;
  localparam int HO = 50;
  typedef struct packed {
    logic [15:0]      len;
    logic [7:0]       nv;
    logic [31:0][7:0] vals;
    logic [7:0]       start;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, trig = 1'b0, ref_in = 1'b0, sweep_dn = 1'b0;
  logic [7:0] gen_start = 8'd100, gen_step = '0, on_cyc = '0;
  logic [7:0] gen_val;
  logic gate, busy, burst_done;
  int checks = 0, errors = 0;
  exp_t q[$];
  burst_seq #(.GEN_PARAMETER(GP), .CYC_W(8), .HOLDOFF_CYC(HO)) dut (
    .clk(clk), .rst(rst), .trig(trig), .ref_in(ref_in), .gen_start(gen_start),
    .gen_step(gen_step), .sweep_dn(sweep_dn), .on_cyc(on_cyc), .gen_val(gen_val),
    .gate(gate), .busy(busy), .burst_done(burst_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic int sweep(input int v, input int s, input bit dn);
    int r;
    r = dn ? v - s : v + s;
    return r < 0 ? 0 : (r > GP ? GP : r);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic burst(input int st, input int stp, input bit dn, input int on, input int h, input int k);
    exp_t e;
    int n, v, w;
    n = k < on ? k : on;
    e = '0;
    e.start = 8'(st > GP ? GP : st);
    e.len = 16'(h * (2 * n - 1));
    v = int'(e.start);
    e.vals[0] = 8'(v);
    e.nv = 1;
    for (int i = 1; i <= 2 * n - 2; i++) begin
      w = sweep(v, stp, dn);
      if (w != v) begin
        e.vals[e.nv] = 8'(w);
        e.nv++;
      end
      v = w;
    end
    q.push_back(e);
    gen_start = 8'(st);
    gen_step = 8'(stp);
    sweep_dn = dn;
    on_cyc = 8'(on);
    trig = 1'b1;
    repeat (HO + 4) tick;
    gen_step = 8'($urandom);
    sweep_dn = 1'($urandom);
    on_cyc = 8'($urandom);
    for (int c = 1; c <= n; c++) begin
      ref_in = 1'b1;
      for (int t = 0; t < h; t++) begin
        if (c == k && t == h / 2) trig = 1'b0;
        tick;
      end
      ref_in = 1'b0;
      repeat (h) tick;
    end
  endtask
  // monitor: measures each burst as the DUT presents it and compares against the queued expectation
  logic prev_gate = 1'b0, prev_done = 1'b0, holding = 1'b0, gapping = 1'b0;
  int len = 0, nv = 0, hcnt = 0, gap = 0;
  logic [7:0] cur [32];
  always @(negedge clk) begin
    if (!rst) begin
      if (gapping) gap++;
      if (gate) begin
        if (!prev_gate) begin
          len = 0;
          nv = 0;
          if (gapping) chk("holdoff_gap", int'(gap > HO), 1);
          gapping = 1'b0;
        end
        len++;
        if (nv == 0 || gen_val != cur[nv - 1]) begin
          if (nv < 32) cur[nv] = gen_val;
          nv++;
        end
      end
      if (prev_gate && !gate) chk("end_has_done", int'(burst_done), 1);
      if (burst_done) begin
        chk("done_width", int'(prev_done), 0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_burst actual=1 expected=0 t=%0t", $time);
        end else begin
          exp_t e;
          int bad;
          e = q.pop_front();
          chk("gate_len", len, int'(e.len));
          chk("sweep_count", nv, int'(e.nv));
          bad = 0;
          for (int i = 0; i < nv && i < int'(e.nv) && i < 32; i++)
            if (cur[i] != e.vals[i]) bad++;
          chk("sweep_vals", bad, 0);
          chk("end_gen_val", int'(gen_val), int'(e.start));
          chk("end_gate", int'(gate), 0);
        end
        holding = 1'b1;
        hcnt = 0;
        gapping = 1'b1;
        gap = 0;
      end
      if (holding) begin
        if (busy) hcnt++;
        else begin
          chk("holdoff_len", hcnt, HO);
          holding = 1'b0;
        end
      end
      prev_gate = gate;
      prev_done = burst_done;
    end
  end
  initial begin
    int cnt;
    #2;
    chk("rst_gen_val", int'(gen_val), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(burst_done), 0);
    tick;
    rst = 1'b0;
    tick;
    chk("idle_gen_val", int'(gen_val), 100);
    chk("idle_busy", int'(busy), 0);
    on_cyc = 8'd2;
    trig = 1'b1;
    tick;
    chk("arm_busy", int'(busy), 1);
    trig = 1'b0;
    tick;
    chk("arm_abort", int'(busy), 0);
    cnt = 0;
    on_cyc = 8'd0;
    trig = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ref_in = 1'(i / 4 % 2);
      tick;
      if (busy || gate) cnt++;
    end
    ref_in = 1'b0;
    chk("disabled_idle", cnt, 0);
    trig = 1'b0;
    tick;
    burst(100, 0, 0, 3, 10, 99);
    burst(50, 0, 0, 10, 10, 2);
    burst(250, 3, 0, 4, 5, 99);
    burst(4, 3, 1, 4, 5, 99);
    for (int i = 0; i < 20; i++)
      burst($urandom_range(0, 255), $urandom_range(0, 40), 1'($urandom_range(0, 1)),
            $urandom_range(1, 12), $urandom_range(2, 8), $urandom_range(1, 14));
    trig = 1'b0;
    repeat (HO + 10) tick;
    chk("pending", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
